tcp_rx_header_parser: RTL and testbench
=======================================

// Module: tcp_rx_header_parser
// PURPOSE
// - Byte-serial TCP segment header parser feeding tcp_server_control.
// - Extracts ports, seq/ack numbers, window and flags from the RX byte stream (first byte = TCP src port MSB).
// - Produces per-segment flag/port-match strobes consumed by the control FSM (FIN_in, RST_in, SYN_port_vld, ACK_port_*_vld).
// - Skips options per data offset and forwards payload bytes downstream.
// PARAMETERS
// - MIN_HDR_BYTES  20  minimum TCP header length; data offset < 5 is an error
// - MAX_HDR_BYTES  60  maximum TCP header length (data offset 15)
// PORTS
// - clk            in   1   clock
// - rst            in   1   synchronous, active-high reset
// - in_vld         in   1   input byte valid
// - in_sof         in   1   first byte of segment (qualified by in_vld)
// - in_eof         in   1   last byte of segment (qualified by in_vld)
// - in_byte        in   8   segment byte
// - in_rdy         out  1   always 1 outside reset; the parser never stalls
// - local_port     in   16  our port for match strobes
// - remote_port    in   16  peer port for match strobes
// - src_port_out   out  16  parsed source port
// - dst_port_out   out  16  parsed destination port
// - seq_num_out    out  32  parsed sequence number
// - ack_num_out    out  32  parsed acknowledgement number
// - window_out     out  16  parsed window
// - FIN_out, SYN_out, RST_out, PSH_out, ACK_out  out  1 each  flag bits 0,1,2,3,4 of byte 13
// - seg_vld        out  1   one-cycle pulse: header complete and all fields valid
// - SYN_port_vld   out  1   pulse with seg_vld: SYN & !ACK & dst==local_port
// - ACK_port_vld   out  1   pulse with seg_vld: ACK & !SYN & src==remote_port & dst==local_port
// - pld_vld, pld_last, pld_byte  out  1,1,8  payload forward (registered, 1-cycle latency)
// - hdr_err        out  1   one-cycle pulse on malformed segment
// BEHAVIOUR
// - Reset: all outputs 0 except in_rdy=0 during rst and 1 afterwards; FSM enters RX_IDLE; counter is 0.
// - FSM states:
//   - RX_IDLE: wait for in_vld&in_sof -> RX_HDR; non-sof bytes are ignored.
//   - RX_HDR: 6-bit byte counter; bytes 0-15 load fields big-endian.
//     - Byte 12 latches data offset from [7:4]; byte 13 latches flags.
//     - At byte 19: offset<5 -> hdr_err, then RX_IDLE (or RX_DRAIN if !eof); offset==5 -> done; else -> RX_OPT.
//   - RX_OPT: discard bytes until counter == 4*offset-1 -> done.
//   - Done: seg_vld plus strobes asserted the cycle after the final header byte; fields hold until the next seg_vld.
//     - If the final header byte had eof -> RX_IDLE; else -> RX_PLD.
//   - RX_PLD: forward each byte; pld_last=in_eof; eof -> RX_IDLE.
//   - RX_DRAIN: drop bytes until eof -> RX_IDLE.
// - Error handling:
//   - eof before header complete -> hdr_err next cycle, no seg_vld, RX_IDLE.
//   - sof while not RX_IDLE -> hdr_err pulse; the sof byte is taken as byte 0 of a new segment.
//   - If an error and a seg_vld would coincide, hdr_err wins.
// - Strobes: port compares use local_port/remote_port sampled at the completing cycle. Bytes 16-19 (checksum, urgent) are discarded.
// - in_vld=0 cycles freeze the counter/FSM; gaps are legal anywhere.
// - Counter never wraps: maximum 59 < 64.
// - Reset mid-segment: state is lost; rest of that segment ignored until the next sof.
// CONFIGURATION
// - TCP_RX_PORT_FILTER_EN defined:
//   - seg_vld, strobes and payload are suppressed when dst_port != local_port; segment drained silently, no hdr_err.
//   - Fields still update.
// - Not defined: every well-formed segment raises seg_vld; only the strobes apply the port match.
// TESTING
// - 20-byte SYN (src 0x1234, dst 0x0050, flags 0x02), local_port=0x0050
//   -> seg_vld=SYN_port_vld=1 one cycle after byte 19; ACK_port_vld=0.
// - ACK segment, offset 8 (12 option bytes) + 4 payload bytes, ports match
//   -> ACK_port_vld after byte 31; pld_vld x4, pld_last on 4th.
// - eof at byte 10 -> hdr_err pulse, no seg_vld, next sof parses normally.
// - Offset=3 -> hdr_err after byte 19; remaining bytes dropped until eof.
// - sof at byte 7 of a segment -> hdr_err; new segment parses fully, seg_vld with new fields.
// - FILTER_EN, dst 0x0051 vs local 0x0050 -> no seg_vld/pld_vld/hdr_err; dst 0x0050 -> seg_vld.
// - Random in_vld gaps on any of the above -> identical results.

Source files
------------

// File: rtl/tcp_rx_header_parser_if.sv
// Byte-stream bundle for the TCP RX header parser: valid/sof/eof framing,
// the segment byte and the (always-ready) back-pressure signal.
interface tcp_rx_header_parser_if;
  logic       in_vld;
  logic       in_sof;
  logic       in_eof;
  logic [7:0] in_byte;
  logic       in_rdy;

  modport master (output in_vld, in_sof, in_eof, in_byte, input in_rdy);
  modport slave  (input in_vld, in_sof, in_eof, in_byte, output in_rdy);
endinterface

// File: rtl/tcp_rx_header_parser.sv
// Byte-serial TCP segment header parser.
// Extracts ports, seq/ack, window and flags, skips options per data offset,
// raises seg_vld plus port-match strobes for the control FSM and forwards
// payload bytes with one cycle of latency.
// Optional feature macro: TCP_RX_PORT_FILTER_EN -- when defined, segments
// whose destination port differs from local_port are drained silently
// (no seg_vld, strobes or payload); parsed fields still update.
module tcp_rx_header_parser #(
  parameter int MIN_HDR_BYTES = 20,
  parameter int MAX_HDR_BYTES = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  tcp_rx_header_parser_if.slave rx,
  input  logic [15:0]           local_port,
  input  logic [15:0]           remote_port,
  output logic [15:0]           src_port_out,
  output logic [15:0]           dst_port_out,
  output logic [31:0]           seq_num_out,
  output logic [31:0]           ack_num_out,
  output logic [15:0]           window_out,
  output logic                  FIN_out,
  output logic                  SYN_out,
  output logic                  RST_out,
  output logic                  PSH_out,
  output logic                  ACK_out,
  output logic                  seg_vld,
  output logic                  SYN_port_vld,
  output logic                  ACK_port_vld,
  output logic                  pld_vld,
  output logic                  pld_last,
  output logic [7:0]            pld_byte,
  output logic                  hdr_err
);

  localparam int CNT_W = $clog2(MAX_HDR_BYTES);
  localparam logic [CNT_W-1:0] LAST_MIN_IDX = CNT_W'(MIN_HDR_BYTES - 1);
  localparam logic [3:0]       MIN_OFF      = 4'(MIN_HDR_BYTES / 4);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_HDR,
    RX_OPT,
    RX_PLD,
    RX_DRAIN
  } rx_state_e;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Shadow header fields, filled byte by byte while the header streams in.
  logic [15:0] src_q, src_d, dst_q, dst_d, win_q, win_d;
  logic [31:0] seq_q, seq_d, ack_q, ack_d;
  logic [3:0]  off_q, off_d;
  logic [4:0]  flags_q, flags_d;

  // Published fields, loaded only when a header completes.
  logic [15:0] src_out_q, src_out_d, dst_out_q, dst_out_d, win_out_q, win_out_d;
  logic [31:0] seq_out_q, seq_out_d, ack_out_q, ack_out_d;
  logic [4:0]  flags_out_q, flags_out_d;

  logic       seg_vld_q, seg_vld_d, syn_pv_q, syn_pv_d, ack_pv_q, ack_pv_d;
  logic       pld_vld_q, pld_vld_d, pld_last_q, pld_last_d, hdr_err_q, hdr_err_d;
  logic [7:0] pld_byte_q, pld_byte_d;

  logic             sof_new, hdr_active, done, err, pass, match;
  logic [CNT_W-1:0] idx, opt_end;

  assign rx.in_rdy = ~rst;

  // Next-state, field capture and output pulse generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    src_d       = src_q;
    dst_d       = dst_q;
    seq_d       = seq_q;
    ack_d       = ack_q;
    win_d       = win_q;
    off_d       = off_q;
    flags_d     = flags_q;
    src_out_d   = src_out_q;
    dst_out_d   = dst_out_q;
    seq_out_d   = seq_out_q;
    ack_out_d   = ack_out_q;
    win_out_d   = win_out_q;
    flags_out_d = flags_out_q;
    seg_vld_d   = 1'b0;
    syn_pv_d    = 1'b0;
    ack_pv_d    = 1'b0;
    pld_vld_d   = 1'b0;
    pld_last_d  = 1'b0;
    pld_byte_d  = pld_byte_q;
    done        = 1'b0;
    err         = 1'b0;
    pass        = 1'b1;
    match       = (dst_q == local_port);
    sof_new     = rx.in_vld & rx.in_sof;
    // A sof byte always restarts header parsing at byte 0, whatever the state.
    hdr_active  = sof_new | (state_q == RX_HDR);
    idx         = sof_new ? '0 : cnt_q;
    opt_end     = CNT_W'({off_q, 2'b00}) - CNT_W'(1);

    if (rx.in_vld) begin
      if (sof_new && state_q != RX_IDLE) err = 1'b1;
      if (hdr_active) begin
        cnt_d = idx + CNT_W'(1);
        case (idx)
          CNT_W'(0):  src_d[15:8]  = rx.in_byte;
          CNT_W'(1):  src_d[7:0]   = rx.in_byte;
          CNT_W'(2):  dst_d[15:8]  = rx.in_byte;
          CNT_W'(3):  dst_d[7:0]   = rx.in_byte;
          CNT_W'(4):  seq_d[31:24] = rx.in_byte;
          CNT_W'(5):  seq_d[23:16] = rx.in_byte;
          CNT_W'(6):  seq_d[15:8]  = rx.in_byte;
          CNT_W'(7):  seq_d[7:0]   = rx.in_byte;
          CNT_W'(8):  ack_d[31:24] = rx.in_byte;
          CNT_W'(9):  ack_d[23:16] = rx.in_byte;
          CNT_W'(10): ack_d[15:8]  = rx.in_byte;
          CNT_W'(11): ack_d[7:0]   = rx.in_byte;
          CNT_W'(12): off_d        = rx.in_byte[7:4];
          CNT_W'(13): flags_d      = rx.in_byte[4:0];
          CNT_W'(14): win_d[15:8]  = rx.in_byte;
          CNT_W'(15): win_d[7:0]   = rx.in_byte;
          default: ;
        endcase
        if (idx == LAST_MIN_IDX) begin
          if (off_q < MIN_OFF) begin
            err     = 1'b1;
            state_d = rx.in_eof ? RX_IDLE : RX_DRAIN;
          end else if (off_q == MIN_OFF) begin
            done = 1'b1;
          end else if (rx.in_eof) begin
            err     = 1'b1;
            state_d = RX_IDLE;
          end else begin
            state_d = RX_OPT;
          end
        end else if (rx.in_eof) begin
          err     = 1'b1;
          state_d = RX_IDLE;
        end else begin
          state_d = RX_HDR;
        end
      end else begin
        case (state_q)
          RX_OPT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == opt_end) begin
              done = 1'b1;
            end else if (rx.in_eof) begin
              err     = 1'b1;
              state_d = RX_IDLE;
            end
          end
          RX_PLD: begin
            pld_vld_d  = 1'b1;
            pld_last_d = rx.in_eof;
            pld_byte_d = rx.in_byte;
            if (rx.in_eof) state_d = RX_IDLE;
          end
          RX_DRAIN: if (rx.in_eof) state_d = RX_IDLE;
          default: ;
        endcase
      end
    end

    if (done) begin
      src_out_d   = src_q;
      dst_out_d   = dst_q;
      seq_out_d   = seq_q;
      ack_out_d   = ack_q;
      win_out_d   = win_q;
      flags_out_d = flags_q;
`ifdef TCP_RX_PORT_FILTER_EN
      pass = match;
`else
      pass = 1'b1;
`endif
      seg_vld_d = pass & ~err;
      syn_pv_d  = seg_vld_d & flags_q[1] & ~flags_q[4] & match;
      ack_pv_d  = seg_vld_d & flags_q[4] & ~flags_q[1] & match & (src_q == remote_port);
      state_d   = rx.in_eof ? RX_IDLE : (pass ? RX_PLD : RX_DRAIN);
    end

    hdr_err_d = err;
  end

  // State, counter, field and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      seq_q       <= '0;
      ack_q       <= '0;
      win_q       <= '0;
      off_q       <= '0;
      flags_q     <= '0;
      src_out_q   <= '0;
      dst_out_q   <= '0;
      seq_out_q   <= '0;
      ack_out_q   <= '0;
      win_out_q   <= '0;
      flags_out_q <= '0;
      seg_vld_q   <= 1'b0;
      syn_pv_q    <= 1'b0;
      ack_pv_q    <= 1'b0;
      pld_vld_q   <= 1'b0;
      pld_last_q  <= 1'b0;
      pld_byte_q  <= '0;
      hdr_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      seq_q       <= seq_d;
      ack_q       <= ack_d;
      win_q       <= win_d;
      off_q       <= off_d;
      flags_q     <= flags_d;
      src_out_q   <= src_out_d;
      dst_out_q   <= dst_out_d;
      seq_out_q   <= seq_out_d;
      ack_out_q   <= ack_out_d;
      win_out_q   <= win_out_d;
      flags_out_q <= flags_out_d;
      seg_vld_q   <= seg_vld_d;
      syn_pv_q    <= syn_pv_d;
      ack_pv_q    <= ack_pv_d;
      pld_vld_q   <= pld_vld_d;
      pld_last_q  <= pld_last_d;
      pld_byte_q  <= pld_byte_d;
      hdr_err_q   <= hdr_err_d;
    end
  end

  assign src_port_out = src_out_q;
  assign dst_port_out = dst_out_q;
  assign seq_num_out  = seq_out_q;
  assign ack_num_out  = ack_out_q;
  assign window_out   = win_out_q;
  assign FIN_out      = flags_out_q[0];
  assign SYN_out      = flags_out_q[1];
  assign RST_out      = flags_out_q[2];
  assign PSH_out      = flags_out_q[3];
  assign ACK_out      = flags_out_q[4];
  assign seg_vld      = seg_vld_q;
  assign SYN_port_vld = syn_pv_q;
  assign ACK_port_vld = ack_pv_q;
  assign pld_vld      = pld_vld_q;
  assign pld_last     = pld_last_q;
  assign pld_byte     = pld_byte_q;
  assign hdr_err      = hdr_err_q;

endmodule

// File: tb/tb_tcp_rx_header_parser.sv
// Directed bench for tcp_rx_header_parser: SYN, ACK with options and
// payload, early eof, bad offset, sof restart and port filtering, repeated
// with random in_vld gaps.
module tb_tcp_rx_header_parser;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tcp_rx_header_parser_if rx_if ();

  logic [15:0] local_port, remote_port;
  logic [15:0] src_port_out, dst_port_out, window_out;
  logic [31:0] seq_num_out, ack_num_out;
  logic        FIN_out, SYN_out, RST_out, PSH_out, ACK_out;
  logic        seg_vld, SYN_port_vld, ACK_port_vld;
  logic        pld_vld, pld_last, hdr_err;
  logic [7:0]  pld_byte;

  tcp_rx_header_parser #(.MIN_HDR_BYTES(20), .MAX_HDR_BYTES(60)) dut (
    .clk(clk), .rst(rst), .rx(rx_if.slave),
    .local_port(local_port), .remote_port(remote_port),
    .src_port_out(src_port_out), .dst_port_out(dst_port_out),
    .seq_num_out(seq_num_out), .ack_num_out(ack_num_out), .window_out(window_out),
    .FIN_out(FIN_out), .SYN_out(SYN_out), .RST_out(RST_out), .PSH_out(PSH_out),
    .ACK_out(ACK_out), .seg_vld(seg_vld), .SYN_port_vld(SYN_port_vld),
    .ACK_port_vld(ACK_port_vld), .pld_vld(pld_vld), .pld_last(pld_last),
    .pld_byte(pld_byte), .hdr_err(hdr_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int seg_cnt  = 0;
  int err_cnt  = 0;
  bit gap_en   = 1'b0;
  logic [7:0] hdr_q[$];
  logic [7:0] pld_q[$];
  logic       last_q[$];

  // Pulse counters and payload capture, sampled 1ns after each rising edge.
  always @(posedge clk) begin
    #1;
    if (seg_vld === 1'b1) seg_cnt++;
    if (hdr_err === 1'b1) err_cnt++;
    if (pld_vld === 1'b1) begin
      pld_q.push_back(pld_byte);
      last_q.push_back(pld_last);
    end
  end

  task automatic idle(input int n);
    rx_if.in_vld = 1'b0; rx_if.in_sof = 1'b0; rx_if.in_eof = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic s, input logic e);
    if (gap_en) idle(int'($urandom_range(0, 2)));
    rx_if.in_vld = 1'b1; rx_if.in_sof = s; rx_if.in_eof = e; rx_if.in_byte = b;
    @(negedge clk);
    rx_if.in_vld = 1'b0; rx_if.in_sof = 1'b0; rx_if.in_eof = 1'b0;
  endtask

  task automatic send_range(input int from, input int to, input bit eof_at_end);
    for (int i = from; i <= to; i++)
      send_byte(hdr_q[i], i == 0, eof_at_end && i == to);
  endtask

  task automatic build(input logic [15:0] src, input logic [15:0] dst,
                       input logic [31:0] seq, input logic [31:0] ack,
                       input logic [3:0] off, input logic [7:0] flags,
                       input logic [15:0] win);
    hdr_q.delete();
    hdr_q.push_back(src[15:8]); hdr_q.push_back(src[7:0]);
    hdr_q.push_back(dst[15:8]); hdr_q.push_back(dst[7:0]);
    for (int i = 3; i >= 0; i--) hdr_q.push_back(seq[8*i +: 8]);
    for (int i = 3; i >= 0; i--) hdr_q.push_back(ack[8*i +: 8]);
    hdr_q.push_back({off, 4'h0}); hdr_q.push_back(flags);
    hdr_q.push_back(win[15:8]); hdr_q.push_back(win[7:0]);
    hdr_q.push_back(8'hAA); hdr_q.push_back(8'h55);
    hdr_q.push_back(8'h00); hdr_q.push_back(8'h00);
    if (off > 4'd5)
      for (int i = 0; i < 4 * int'(off) - 20; i++) hdr_q.push_back(8'h01);
  endtask

  task automatic test_reset();
    rst = 1'b1; local_port = 16'h0050; remote_port = 16'h1234;
    rx_if.in_byte = 8'h00;
    idle(3);
    n_checks++; if (rx_if.in_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_in_rdy: got %b want 0", rx_if.in_rdy); end
    n_checks++; if ({seg_vld, hdr_err, pld_vld, SYN_port_vld, ACK_port_vld} !== 5'b0) begin n_fail++; $display("FAIL reset_pulses: got %b want 00000", {seg_vld, hdr_err, pld_vld, SYN_port_vld, ACK_port_vld}); end
    n_checks++; if ({src_port_out, seq_num_out} !== 48'h0) begin n_fail++; $display("FAIL reset_fields: got %h want 0", {src_port_out, seq_num_out}); end
    rst = 1'b0;
    idle(1);
    n_checks++; if (rx_if.in_rdy !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_rdy: got %b want 1", rx_if.in_rdy); end
  endtask

  task automatic test_syn();
    int s0, e0;
    local_port = 16'h0050; remote_port = 16'h1234;
    build(16'h1234, 16'h0050, 32'h01020304, 32'h0, 4'd5, 8'h02, 16'hFFFF);
    s0 = seg_cnt; e0 = err_cnt;
    send_range(0, 19, 1'b1);
    n_checks++; if ({seg_vld, SYN_port_vld, ACK_port_vld} !== 3'b110) begin n_fail++; $display("FAIL syn_strobes: got %b want 110", {seg_vld, SYN_port_vld, ACK_port_vld}); end
    n_checks++; if ({src_port_out, dst_port_out} !== 32'h1234_0050) begin n_fail++; $display("FAIL syn_ports: got %h want 12340050", {src_port_out, dst_port_out}); end
    n_checks++; if ({seq_num_out, window_out} !== 48'h01020304_FFFF) begin n_fail++; $display("FAIL syn_seq_win: got %h want 01020304ffff", {seq_num_out, window_out}); end
    n_checks++; if ({ACK_out, PSH_out, RST_out, SYN_out, FIN_out} !== 5'b00010) begin n_fail++; $display("FAIL syn_flags: got %b want 00010", {ACK_out, PSH_out, RST_out, SYN_out, FIN_out}); end
    idle(2);
    n_checks++; if (seg_vld !== 1'b0) begin n_fail++; $display("FAIL syn_pulse_len: got %b want 0", seg_vld); end
    n_checks++; if (seg_cnt - s0 != 1 || err_cnt - e0 != 0) begin n_fail++; $display("FAIL syn_counts: got seg %0d err %0d want 1 0", seg_cnt - s0, err_cnt - e0); end
  endtask

  task automatic test_ack_opt_pld();
    int s0;
    local_port = 16'h0050; remote_port = 16'hC000;
    build(16'hC000, 16'h0050, 32'hDEADBEEF, 32'h11223344, 4'd8, 8'h10, 16'h2000);
    hdr_q.push_back(8'hA1); hdr_q.push_back(8'hA2);
    hdr_q.push_back(8'hA3); hdr_q.push_back(8'hA4);
    pld_q.delete(); last_q.delete(); s0 = seg_cnt;
    send_range(0, 31, 1'b0);
    n_checks++; if ({seg_vld, SYN_port_vld, ACK_port_vld} !== 3'b101) begin n_fail++; $display("FAIL ack_strobes: got %b want 101", {seg_vld, SYN_port_vld, ACK_port_vld}); end
    n_checks++; if ({ack_num_out, ACK_out} !== {32'h11223344, 1'b1}) begin n_fail++; $display("FAIL ack_fields: got %h %b want 11223344 1", ack_num_out, ACK_out); end
    send_range(32, 35, 1'b1);
    idle(2);
    n_checks++; if (pld_q.size() != 4) begin n_fail++; $display("FAIL ack_pld_count: got %0d want 4", pld_q.size()); end
    else begin
      n_checks++; if ({pld_q[0], pld_q[1], pld_q[2], pld_q[3]} !== 32'hA1A2A3A4) begin n_fail++; $display("FAIL ack_pld_bytes: got %h want a1a2a3a4", {pld_q[0], pld_q[1], pld_q[2], pld_q[3]}); end
      n_checks++; if ({last_q[0], last_q[1], last_q[2], last_q[3]} !== 4'b0001) begin n_fail++; $display("FAIL ack_pld_last: got %b want 0001", {last_q[0], last_q[1], last_q[2], last_q[3]}); end
    end
    n_checks++; if (seg_cnt - s0 != 1) begin n_fail++; $display("FAIL ack_seg_count: got %0d want 1", seg_cnt - s0); end
  endtask

  task automatic test_eof_early();
    int s0, e0;
    local_port = 16'h0050; remote_port = 16'h1234;
    build(16'h1234, 16'h0050, 32'h0A0B0C0D, 32'h0, 4'd5, 8'h02, 16'h0100);
    s0 = seg_cnt; e0 = err_cnt;
    send_range(0, 10, 1'b1);
    n_checks++; if ({hdr_err, seg_vld} !== 2'b10) begin n_fail++; $display("FAIL eof_early_pulse: got %b want 10", {hdr_err, seg_vld}); end
    idle(2);
    n_checks++; if (seg_cnt - s0 != 0 || err_cnt - e0 != 1) begin n_fail++; $display("FAIL eof_early_counts: got seg %0d err %0d want 0 1", seg_cnt - s0, err_cnt - e0); end
    n_checks++; if (src_port_out !== 16'hC000) begin n_fail++; $display("FAIL eof_early_hold: got %h want c000", src_port_out); end
    send_range(0, 19, 1'b1);
    n_checks++; if ({seg_vld, seq_num_out} !== {1'b1, 32'h0A0B0C0D}) begin n_fail++; $display("FAIL eof_early_recover: got %b %h want 1 0a0b0c0d", seg_vld, seq_num_out); end
    idle(1);
  endtask

  task automatic test_bad_offset();
    int s0, e0;
    build(16'h1234, 16'h0050, 32'h1, 32'h2, 4'd3, 8'h02, 16'h0);
    for (int i = 0; i < 5; i++) hdr_q.push_back(8'hEE);
    pld_q.delete(); s0 = seg_cnt; e0 = err_cnt;
    send_range(0, 19, 1'b0);
    n_checks++; if ({hdr_err, seg_vld} !== 2'b10) begin n_fail++; $display("FAIL bad_off_pulse: got %b want 10", {hdr_err, seg_vld}); end
    send_range(20, 24, 1'b1);
    idle(2);
    n_checks++; if (seg_cnt - s0 != 0 || err_cnt - e0 != 1 || pld_q.size() != 0) begin n_fail++; $display("FAIL bad_off_drain: got seg %0d err %0d pld %0d want 0 1 0", seg_cnt - s0, err_cnt - e0, pld_q.size()); end
  endtask

  task automatic test_sof_restart();
    int s0, e0;
    local_port = 16'h0050; remote_port = 16'h1234;
    build(16'h1111, 16'h0050, 32'h99999999, 32'h0, 4'd5, 8'h02, 16'h0);
    s0 = seg_cnt; e0 = err_cnt;
    send_range(0, 6, 1'b0);
    build(16'hABCD, 16'h0050, 32'h55667788, 32'h0, 4'd5, 8'h02, 16'h0);
    send_range(0, 0, 1'b0);
    n_checks++; if (hdr_err !== 1'b1) begin n_fail++; $display("FAIL sof_restart_err: got %b want 1", hdr_err); end
    send_range(1, 19, 1'b1);
    n_checks++; if ({seg_vld, src_port_out, seq_num_out} !== {1'b1, 16'hABCD, 32'h55667788}) begin n_fail++; $display("FAIL sof_restart_seg: got %b %h %h want 1 abcd 55667788", seg_vld, src_port_out, seq_num_out); end
    idle(2);
    n_checks++; if (seg_cnt - s0 != 1 || err_cnt - e0 != 1) begin n_fail++; $display("FAIL sof_restart_counts: got seg %0d err %0d want 1 1", seg_cnt - s0, err_cnt - e0); end
  endtask

  task automatic test_port_filter();
    int s0, e0;
    local_port = 16'h0050; remote_port = 16'h1234;
    build(16'h1234, 16'h0051, 32'h77, 32'h0, 4'd5, 8'h02, 16'h0);
    hdr_q.push_back(8'hB1); hdr_q.push_back(8'hB2);
    pld_q.delete(); s0 = seg_cnt; e0 = err_cnt;
    send_range(0, 19, 1'b0);
`ifdef TCP_RX_PORT_FILTER_EN
    n_checks++; if ({seg_vld, SYN_port_vld, hdr_err} !== 3'b000) begin n_fail++; $display("FAIL filter_drop: got %b want 000", {seg_vld, SYN_port_vld, hdr_err}); end
`else
    n_checks++; if ({seg_vld, SYN_port_vld, hdr_err} !== 3'b100) begin n_fail++; $display("FAIL nofilter_seg: got %b want 100", {seg_vld, SYN_port_vld, hdr_err}); end
`endif
    n_checks++; if (dst_port_out !== 16'h0051) begin n_fail++; $display("FAIL filter_fields: got %h want 0051", dst_port_out); end
    send_range(20, 21, 1'b1);
    idle(2);
`ifdef TCP_RX_PORT_FILTER_EN
    n_checks++; if (pld_q.size() != 0 || err_cnt - e0 != 0 || seg_cnt - s0 != 0) begin n_fail++; $display("FAIL filter_silent: got pld %0d err %0d seg %0d want 0 0 0", pld_q.size(), err_cnt - e0, seg_cnt - s0); end
`else
    n_checks++; if (pld_q.size() != 2 || err_cnt - e0 != 0 || seg_cnt - s0 != 1) begin n_fail++; $display("FAIL nofilter_pld: got pld %0d err %0d seg %0d want 2 0 1", pld_q.size(), err_cnt - e0, seg_cnt - s0); end
`endif
    build(16'h1234, 16'h0050, 32'h78, 32'h0, 4'd5, 8'h02, 16'h0);
    send_range(0, 19, 1'b1);
    n_checks++; if ({seg_vld, SYN_port_vld} !== 2'b11) begin n_fail++; $display("FAIL filter_match: got %b want 11", {seg_vld, SYN_port_vld}); end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_syn();
    test_ack_opt_pld();
    test_eof_early();
    test_bad_offset();
    test_sof_restart();
    test_port_filter();
    gap_en = 1'b1;
    test_syn();
    test_ack_opt_pld();
    test_eof_early();
    test_bad_offset();
    test_sof_restart();
    test_port_filter();
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
